// File: rtl/dma_busmaster.sv
// dma_busmaster: 68030 bus initiator. Arbitrates with /BR-/BG-/BGACK, then runs
// asynchronous cycles with dynamic bus sizing for one local operand request.
module dma_busmaster #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req,
  input  logic [31:0] req_addr,
  input  logic        req_rnw,
  input  logic [1:0]  req_siz,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        nBR,
  input  logic        nBG,
  output logic        nBGACK,
  input  logic        nASI,
  output logic        BUS_OE,
  output logic [31:0] ADDR,
  output logic [1:0]  SIZ,
  output logic        RnW,
  output logic        nAS,
  output logic        nDS,
  output logic [31:0] DATA_OUT,
  output logic        DATA_OE,
  input  logic [31:0] DATA_IN,
  input  logic [1:0]  nDSACK,
  input  logic        nBERR
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ARB    = 4'd1,
    S_OWN    = 4'd2,
    S_ADDR   = 4'd3,
    S_ASSERT = 4'd4,
    S_WDS    = 4'd5,
    S_WAIT   = 4'd6,
    S_END    = 4'd7,
    S_NEG    = 4'd8,
    S_REL    = 4'd9
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  state_t      next_state;

  logic [1:0]  nbg_sync;
  logic [1:0]  nasi_sync;
  logic [1:0]  nberr_sync;
  logic [1:0]  dsack_meta;
  logic [1:0]  dsack_sync;
  logic        nbg_safe;
  logic        nasi_safe;
  logic        nberr_safe;

  logic [31:0] cur_addr;
  logic [2:0]  rem;
  logic [31:0] wreg;
  logic        rnw_op;
  logic        err_flag;
  logic [7:0]  wait_cnt;

  logic [2:0]  req_bytes;
  logic [5:0]  req_shift;
  logic [2:0]  step;
  logic        term_ok;
  logic        abort;
  logic        accept;

  // Bytes one cycle moves for a given port width, remaining count and offset.
  function automatic logic [2:0] xfer_bytes(input logic [1:0] port,
                                            input logic [2:0] left,
                                            input logic [1:0] a);
    logic [2:0] lim;
    case (port)
      2'b00:   lim = 3'd4 - {1'b0, a};
      2'b01:   lim = 3'd2 - {2'b00, a[0]};
      default: lim = 3'd1;
    endcase
    return (left < lim) ? left : lim;
  endfunction

  function automatic logic [1:0] first_lane(input logic [1:0] port, input logic [1:0] a);
    logic [1:0] lane;
    case (port)
      2'b00:   lane = a;
      2'b01:   lane = {1'b0, a[0]};
      default: lane = 2'b00;
    endcase
    return lane;
  endfunction

  // Operand bytes replicated onto the lanes the 68030 would drive for offset a.
  function automatic logic [31:0] write_lanes(input logic [31:0] r, input logic [1:0] a);
    logic [7:0] r0, r1, r2, r3, d15, d7;
    {r0, r1, r2, r3} = r;
    case (a)
      2'b00:   begin d15 = r2; d7 = r3; end
      2'b01:   begin d15 = r1; d7 = r2; end
      2'b10:   begin d15 = r0; d7 = r1; end
      default: begin d15 = r0; d7 = r0; end
    endcase
    return {r0, (a[0] ? r0 : r1), d15, d7};
  endfunction

  function automatic logic [31:0] shift_in(input logic [31:0] acc,
                                           input logic [31:0] data,
                                           input logic [1:0]  first,
                                           input logic [2:0]  count);
    logic [31:0] res;
    logic [1:0]  lane;
    res = acc;
    for (int i = 0; i < 4; i++) begin
      lane = first + 2'(i);
      if (i < int'(count)) begin
        res = {res[23:0], data[8*(3-int'(lane)) +: 8]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign nbg_safe   = nbg_sync[1];
  assign nasi_safe  = nasi_sync[1];
  assign nberr_safe = nberr_sync[1];
  assign req_bytes  = (req_siz == 2'b00) ? 3'd4 : {1'b0, req_siz};
  assign req_shift  = {3'd4 - req_bytes, 3'b000};
  assign accept     = (state == S_IDLE) && req;

  // Two-flop synchronizers; all bus decisions use the second stage.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      nbg_sync   <= 2'b11;
      nasi_sync  <= 2'b11;
      nberr_sync <= 2'b11;
      dsack_meta <= 2'b11;
      dsack_sync <= 2'b11;
    end else begin
      nbg_sync   <= {nbg_sync[0], nBG};
      nasi_sync  <= {nasi_sync[0], nASI};
      nberr_sync <= {nberr_sync[0], nBERR};
      dsack_meta <= nDSACK;
      dsack_sync <= dsack_meta;
    end
  end

  // Termination decode in WAIT; /BERR outranks DSACK.
  always_comb begin
    term_ok = 1'b0;
    abort   = 1'b0;
    step    = xfer_bytes(dsack_sync, rem, cur_addr[1:0]);
    if (state == S_WAIT) begin
      if (!nberr_safe) begin
        abort = 1'b1;
      end else if (dsack_sync != 2'b11) begin
        term_ok = 1'b1;
      end else if (wait_cnt == TIMEOUT_CNT) begin
        abort = 1'b1;
      end else begin
        abort = 1'b0;
      end
    end else begin
      term_ok = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = req ? S_ARB : S_IDLE;
      S_ARB:    next_state = (!nbg_safe && nasi_safe) ? S_OWN : S_ARB;
      S_OWN:    next_state = S_ADDR;
      S_ADDR:   next_state = S_ASSERT;
      S_ASSERT: next_state = rnw_op ? S_WAIT : S_WDS;
      S_WDS:    next_state = S_WAIT;
      S_WAIT:   next_state = (term_ok || abort) ? S_END : S_WAIT;
      S_END:    next_state = S_NEG;
      S_NEG: begin
        if ((dsack_sync == 2'b11) && nberr_safe) begin
          next_state = ((rem != 3'd0) && !err_flag) ? S_ADDR : S_REL;
        end else begin
          next_state = S_NEG;
        end
      end
      S_REL:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Operand datapath: address, remaining count, write register, read accumulator.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cur_addr <= 32'd0;
      rem      <= 3'd0;
      wreg     <= 32'd0;
      rnw_op   <= 1'b1;
      err_flag <= 1'b0;
      rdata    <= 32'd0;
    end else if (accept) begin
      cur_addr <= req_addr;
      rem      <= req_bytes;
      wreg     <= req_wdata << req_shift;
      rnw_op   <= req_rnw;
      err_flag <= 1'b0;
      rdata    <= 32'd0;
    end else if (term_ok) begin
      // Data is still held by the target here: DSACK is only seen after sync.
      if (rnw_op) begin
        rdata <= shift_in(rdata, DATA_IN, first_lane(dsack_sync, cur_addr[1:0]), step);
      end else begin
        rdata <= rdata;
      end
      cur_addr <= cur_addr + {29'd0, step};
      rem      <= rem - step;
      wreg     <= wreg << {step, 3'b000};
    end else if (abort) begin
      err_flag <= 1'b1;
    end else begin
      err_flag <= err_flag;
    end
  end

  // WAIT-state termination timer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt <= 8'd0;
    end else if ((state != S_WAIT) && (next_state == S_WAIT)) begin
      wait_cnt <= 8'd0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Registered bus and handshake outputs, decoded from the state being entered.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      nBR      <= 1'b1;
      nBGACK   <= 1'b1;
      BUS_OE   <= 1'b0;
      nAS      <= 1'b1;
      nDS      <= 1'b1;
      DATA_OE  <= 1'b0;
      RnW      <= 1'b1;
      ADDR     <= 32'd0;
      SIZ      <= 2'b00;
      DATA_OUT <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      nBR     <= (next_state != S_ARB);
      nBGACK  <= !(next_state inside {S_OWN, S_ADDR, S_ASSERT, S_WDS, S_WAIT, S_END, S_NEG});
      BUS_OE  <= (next_state inside {S_OWN, S_ADDR, S_ASSERT, S_WDS, S_WAIT, S_END, S_NEG});
      nAS     <= !(next_state inside {S_ASSERT, S_WDS, S_WAIT});
      nDS     <= !(((next_state == S_ASSERT) && rnw_op) || (next_state inside {S_WDS, S_WAIT}));
      DATA_OE <= !rnw_op && (next_state inside {S_ASSERT, S_WDS, S_WAIT, S_END, S_NEG});
      busy    <= (next_state != S_IDLE);
      done    <= (next_state == S_REL);
      err     <= (next_state == S_REL) ? err_flag : 1'b0;
      if ((next_state == S_ADDR) && (state != S_ADDR)) begin
        ADDR     <= cur_addr;
        SIZ      <= rem[1:0];
        RnW      <= rnw_op;
        DATA_OUT <= write_lanes(wreg, cur_addr[1:0]);
      end else begin
        ADDR     <= ADDR;
        SIZ      <= SIZ;
        RnW      <= RnW;
        DATA_OUT <= DATA_OUT;
      end
    end
  end

endmodule

// File: tb/tb_dma_busmaster.sv
// Bench for dma_busmaster: byte-memory bus target with selectable port width,
// wait states and /BERR, plus a scoreboard of expected bus cycles and completions.
module tb_dma_busmaster;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req;
  logic [31:0] req_addr;
  logic        req_rnw;
  logic [1:0]  req_siz;
  logic [31:0] req_wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        nBR, nBG, nBGACK, nASI, BUS_OE;
  logic [31:0] ADDR;
  logic [1:0]  SIZ;
  logic        RnW, nAS, nDS, DATA_OE;
  logic [31:0] DATA_OUT, DATA_IN;
  logic [1:0]  nDSACK;
  logic        nBERR;

  always #5 CLK = ~CLK;

  dma_busmaster #(.TIMEOUT(255)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .req_addr(req_addr), .req_rnw(req_rnw),
    .req_siz(req_siz), .req_wdata(req_wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .nBR(nBR), .nBG(nBG), .nBGACK(nBGACK), .nASI(nASI), .BUS_OE(BUS_OE),
    .ADDR(ADDR), .SIZ(SIZ), .RnW(RnW), .nAS(nAS), .nDS(nDS), .DATA_OUT(DATA_OUT),
    .DATA_OE(DATA_OE), .DATA_IN(DATA_IN), .nDSACK(nDSACK), .nBERR(nBERR)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  siz;
    logic        rnw;
  } cyc_t;

  typedef struct {
    logic        err;
    logic        rnw;
    logic [31:0] rdata;
    logic [31:0] addr;
    int          n;
    logic [31:0] wdata;
  } cmp_t;

  cyc_t       cyc_q[$];
  cmp_t       cmp_q[$];
  logic [7:0] mem [0:1023];
  int         checks = 0;
  int         errors = 0;

  int tgt_port = 0;
  int tgt_ws = 0;
  int tgt_berr_idx = -1;
  int tgt_cyc = 0;
  bit tgt_silent = 1'b0;

  function automatic int midx(input logic [31:0] x);
    return int'(x[9:0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_nBR"}, {31'd0, nBR}, 32'd1);
    chk({tag, "_nBGACK"}, {31'd0, nBGACK}, 32'd1);
    chk({tag, "_nAS"}, {31'd0, nAS}, 32'd1);
    chk({tag, "_nDS"}, {31'd0, nDS}, 32'd1);
    chk({tag, "_RnW"}, {31'd0, RnW}, 32'd1);
    chk({tag, "_BUS_OE"}, {31'd0, BUS_OE}, 32'd0);
    chk({tag, "_DATA_OE"}, {31'd0, DATA_OE}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_ADDR"}, ADDR, 32'd0);
    chk({tag, "_SIZ"}, {30'd0, SIZ}, 32'd0);
    chk({tag, "_DATA_OUT"}, DATA_OUT, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  // Bus target: byte memory seen through an 8/16/32-bit port.
  initial begin : target
    logic [31:0] a, base;
    int rem, w, off, k;
    nDSACK  = 2'b11;
    nBERR   = 1'b1;
    DATA_IN = 32'd0;
    forever begin
      @(posedge CLK); #1;
      if (nRST && !nAS && BUS_OE) begin
        a    = ADDR;
        rem  = (SIZ == 2'b00) ? 4 : int'(SIZ);
        w    = (tgt_port == 0) ? 4 : ((tgt_port == 1) ? 2 : 1);
        off  = int'(a[1:0]) % w;
        base = a - 32'(off);
        k    = (rem < w - off) ? rem : (w - off);
        if (!RnW) begin
          for (int t = 0; t < 8 && nDS; t++) begin @(posedge CLK); #1; end
        end
        repeat (tgt_ws) begin @(posedge CLK); #1; end
        if (!tgt_silent && nRST && !nAS) begin
          if (tgt_cyc == tgt_berr_idx) begin
            nBERR = 1'b0;
          end else begin
            if (RnW) begin
              DATA_IN = $urandom;
              for (int j = 0; j < w; j++) DATA_IN[31-8*j -: 8] = mem[midx(base + 32'(j))];
            end else begin
              chk("write_data_oe", {31'd0, DATA_OE}, 32'd1);
              for (int j = off; j < off + k; j++) mem[midx(base + 32'(j))] = DATA_OUT[31-8*j -: 8];
            end
            nDSACK = (tgt_port == 0) ? 2'b00 : ((tgt_port == 1) ? 2'b01 : 2'b10);
          end
        end
        tgt_cyc++;
        for (int t = 0; t < 600 && !nAS; t++) begin @(posedge CLK); #1; end
        nDSACK = 2'b11;
        nBERR  = 1'b1;
      end
    end
  end

  // Monitor: pops expected cycles on each /AS assertion and expected results on done.
  initial begin : monitor
    logic prev_nas;
    cyc_t c;
    cmp_t e;
    prev_nas = 1'b1;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        prev_nas = 1'b1;
      end else begin
        if (prev_nas && !nAS) begin
          if (cyc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cycle: got cycle at %h, expected none", ADDR);
          end else begin
            c = cyc_q.pop_front();
            chk("cycle_addr", ADDR, c.addr);
            chk("cycle_siz", {30'd0, SIZ}, {30'd0, c.siz});
            chk("cycle_rnw", {31'd0, RnW}, {31'd0, c.rnw});
          end
        end
        if (done) begin
          if (cmp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done, expected none");
          end else begin
            e = cmp_q.pop_front();
            chk("done_err", {31'd0, err}, {31'd0, e.err});
            chk("done_busy", {31'd0, busy}, 32'd1);
            if (!e.err && e.rnw) chk("read_data", rdata, e.rdata);
            if (!e.err && !e.rnw) begin
              for (int i = 0; i < e.n; i++)
                chk("write_byte", {24'd0, mem[midx(e.addr + 32'(i))]},
                    {24'd0, e.wdata[8*(e.n-1-i) +: 8]});
            end
          end
        end
        prev_nas = nAS;
      end
    end
  end

  // Reference model: expected cycles from the sizing rules, expected result from memory.
  task automatic do_txn(input logic [31:0] addr, input logic [1:0] siz, input logic rnw,
                        input logic [31:0] wdata, input int port, input int ws,
                        input int berr_idx, input bit silent, input bit arb, output int lat);
    int n, w, rem, k, off, idx;
    logic [31:0] a;
    cyc_t c;
    cmp_t e;
    bit got, seen;
    n = (siz == 2'b00) ? 4 : int'(siz);
    w = (port == 0) ? 4 : ((port == 1) ? 2 : 1);
    a = addr; rem = n; idx = 0; e.err = 1'b0;
    while (rem > 0) begin
      c.addr = a; c.siz = 2'(rem % 4); c.rnw = rnw;
      cyc_q.push_back(c);
      if (silent || idx == berr_idx) begin
        e.err = 1'b1;
        break;
      end
      off = int'(a[1:0]) % w;
      k = (rem < w - off) ? rem : (w - off);
      a = a + 32'(k); rem = rem - k; idx++;
    end
    e.rnw = rnw; e.n = n; e.addr = addr; e.wdata = wdata; e.rdata = 32'd0;
    for (int i = 0; i < n; i++) e.rdata = {e.rdata[23:0], mem[midx(addr + 32'(i))]};
    cmp_q.push_back(e);
    tgt_port = port; tgt_ws = ws; tgt_berr_idx = berr_idx; tgt_silent = silent; tgt_cyc = 0;
    @(negedge CLK);
    req = 1'b1; req_addr = addr; req_siz = siz; req_rnw = rnw; req_wdata = wdata;
    @(posedge CLK); #1;
    // Keep req high with junk operands: it must be ignored while busy and in the done cycle.
    req_addr = $urandom; req_wdata = $urandom; req_rnw = 1'($urandom); req_siz = 2'($urandom);
    lat = 0;
    if (arb) begin
      seen = 1'b0;
      repeat (50) begin @(negedge CLK); lat++; if (!nAS) seen = 1'b1; end
      chk("arb_nbr", {31'd0, nBR}, 32'd0);
      nBG = 1'b0; nASI = 1'b0;
      repeat (20) begin @(negedge CLK); lat++; if (!nAS || !nBGACK) seen = 1'b1; end
      chk("arb_waits_for_idle", {31'd0, seen}, 32'd0);
      nASI = 1'b1;
    end
    got = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge CLK);
      lat++;
      if (done) begin got = 1'b1; break; end
    end
    req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: got no done, expected done within 2000 clocks");
    end
  endtask

  initial begin : stimulus
    int lat, berr_idx;
    logic [31:0] ra;
    nRST = 1'b0; req = 1'b0; req_addr = 32'd0; req_rnw = 1'b1; req_siz = 2'b00;
    req_wdata = 32'd0; nBG = 1'b0; nASI = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    nRST = 1'b1;
    repeat (3) @(negedge CLK);

    mem[midx(32'h1000)] = 8'hDE; mem[midx(32'h1001)] = 8'hAD;
    mem[midx(32'h1002)] = 8'hBE; mem[midx(32'h1003)] = 8'hEF;
    do_txn(32'h0000_1000, 2'b00, 1'b1, 32'd0, 0, 0, -1, 1'b0, 1'b0, lat);
    chk("long_read_latency", 32'(lat), 32'd10);

    do_txn(32'h0000_0201, 2'b00, 1'b0, 32'h1122_3344, 2, 1, -1, 1'b0, 1'b0, lat);

    mem[midx(32'h103)] = 8'hAB; mem[midx(32'h104)] = 8'hCD;
    do_txn(32'h0000_0103, 2'b10, 1'b1, 32'd0, 1, 0, -1, 1'b0, 1'b0, lat);

    do_txn(32'h0000_0302, 2'b00, 1'b0, 32'hA5A5_5A5A, 0, 1, 0, 1'b0, 1'b0, lat);
    chk("berr_bus_released", {31'd0, nBGACK}, 32'd1);

    do_txn(32'h0000_0040, 2'b00, 1'b1, 32'd0, 0, 0, -1, 1'b1, 1'b0, lat);
    chk("timeout_latency", {31'd0, (lat >= 258 && lat <= 268)}, 32'd1);
    chk("timeout_bus_off", {31'd0, BUS_OE}, 32'd0);

    nBG = 1'b1;
    do_txn(32'h0000_0080, 2'b01, 1'b1, 32'd0, 0, 2, -1, 1'b0, 1'b1, lat);

    for (int r = 0; r < 40; r++) begin
      berr_idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_txn($urandom, 2'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)), berr_idx, 1'b0, 1'b0, lat);
    end

    // Reset in the middle of a write cycle held in WAIT by a silent target.
    ra = 32'h0000_0155;
    cyc_q.push_back('{addr: ra, siz: 2'b10, rnw: 1'b0});
    tgt_silent = 1'b1; tgt_cyc = 0;
    @(negedge CLK);
    req = 1'b1; req_addr = ra; req_siz = 2'b10; req_rnw = 1'b0; req_wdata = 32'h0000_BEEF;
    @(negedge CLK);
    req = 1'b0;
    repeat (20) @(negedge CLK);
    chk("pre_reset_nas", {31'd0, nAS}, 32'd0);
    #2 nRST = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge CLK);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);

    do_txn(32'h0000_0010, 2'b11, 1'b1, 32'd0, 0, 0, -1, 1'b0, 1'b0, lat);
    repeat (5) @(negedge CLK);
    chk("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
    chk("result_queue_drained", 32'(cmp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_busmaster.md
# dma_busmaster

Synchronous 68030-bus initiator for the Playground 68030 DMA and memory-test engines. It takes one local operand request, arbitrates for the CPU bus with /BR, /BG and /BGACK, and runs asynchronous bus cycles that terminate on /DSACK[1:0] or /BERR. It implements dynamic bus sizing, so targets such as the DRAM controller, 16-bit peripherals and 8-bit peripherals all see CPU-identical cycles. Bus-side outputs drive external 3-state and open-drain buffers.
## Interface
- TIMEOUT, 255: clocks in WAIT without termination before the block aborts with err.
- CLK  in  1  clock, 50 MHz DRAM clock domain.
- nRST  in  1  reset, asynchronous, active-low.
- req  in  1  request strobe; sampled only in IDLE.
- req_addr  in  32  operand byte address.
- req_rnw  in  1  1 = read, 0 = write.
- req_siz  in  2  operand size, 68030 encoding: 00 = 4 bytes, 01 = 1 byte, 10 = 2 bytes, 11 = 3 bytes.
- req_wdata  in  32  write operand, right-justified.
- busy  out  1  high from the accept edge through the done cycle.
- done  out  1  one-clock completion pulse.
- err  out  1  valid with done; 1 = /BERR or timeout.
- rdata  out  32  read operand, right-justified, zero-filled above; held until the next accept.
- nBR  out  1  bus request, active-low.
- nBG  in  1  bus grant, active-low, asynchronous.
- nBGACK  out  1  bus grant acknowledge, active-low.
- nASI  in  1  bus /AS as driven by the current master; used to detect bus idle.
- BUS_OE  out  1  enables the ADDR, SIZ, RnW, nAS and nDS buffers.
- ADDR  out  32  cycle address.
- SIZ  out  2  remaining byte count, same encoding as req_siz.
- RnW  out  1  bus read/write.
- nAS, nDS  out  1 each  address strobe and data strobe.
- DATA_OUT  out  32  write data lanes; D31:24 is lane 0.
- DATA_OE  out  1  write data buffer enable.
- DATA_IN  in  32  read data lanes.
- nDSACK  in  2  00 = 32-bit port, 01 = 16-bit port (/DSACK1 only), 10 = 8-bit port, 11 = wait.
- nBERR  in  1  bus error, active-low.
## Operation
- nBG, nASI, nDSACK and nBERR are each synchronized through two flops. All decisions use the synchronized copies.
- Accept: in IDLE with req=1, capture all req_* inputs and form n bytes (siz 00 → 4). The write register R is req_wdata << 8·(4−n), so R0 sits at bits 31:24. Raise busy.
- States and transitions:
  - IDLE → ARB on accept.
  - ARB: hold nBR=0; go to OWN when nBG=0 and nASI=1.
  - OWN: nBGACK=0, nBR=1, BUS_OE=1.
  - ADDR: drive ADDR, SIZ (remaining count) and RnW.
  - ASSERT: nAS=0. On a read, nDS=0 in the same cycle. On a write, DATA_OE=1 and nDS=0 one state later (WDS).
  - WAIT: loop until termination.
  - END: latch read data; nAS=1, nDS=1.
  - NEG: wait for nDSACK=11 and nBERR=1. Then go to ADDR if bytes remain, otherwise to REL.
  - REL: nBGACK=1, BUS_OE=0, DATA_OE=0; pulse done; go to IDLE.
- Bytes moved per cycle (k): 32-bit port → min(rem, 4−a[1:0]); 16-bit port → min(rem, 2−a[0]); 8-bit port → 1. After each cycle: a += k, rem −= k, R <<= 8k.
- Write lanes, with a = a[1:0]:
  - D31:24 = R0.
  - D23:16 = a[0] ? R0 : R1.
  - D15:8 = {R2, R1, R0, R0}[a].
  - D7:0 = {R3, R2, R1, R0}[a].
- Read bytes are taken from consecutive lanes:
  - 32-bit port: starting at lane a.
  - 16-bit port: starting at lane a[0].
  - 8-bit port: lane 0.
  - The bytes are shifted into an accumulator, MSB first.
- If /BERR is seen in WAIT (checked with priority over DSACK) or the timeout expires: go END → NEG → REL with err=1. Remaining bytes are abandoned and rdata is unspecified.
## Timing
- Reset values: nBR, nBGACK, nAS, nDS and RnW = 1. BUS_OE, DATA_OE, busy, done and err = 0. ADDR, SIZ, DATA_OUT and rdata = 0. State = IDLE.
- Reset mid-cycle returns to these values immediately; the synchronizers clear to the negated level.
- Synchronizer latency is 2 clocks. With nBG already low, a 1-cycle, 32-bit-port long read gives accept → done in 10 clocks, plus the target's wait states.
- ADDR, SIZ, RnW and DATA_OUT are stable from ADDR through NEG. nAS/nDS negate together in END.
- The WAIT counter resets on entry to WAIT; at count == TIMEOUT the block aborts.
- A req arriving while busy is ignored. A req in the same cycle as done is also ignored; accept is possible from the next IDLE cycle.
## Test plan
- Long read at 0x00001000 from a 32-bit port, DATA_IN = 0xDEADBEEF → one cycle with SIZ=00; done, err=0, rdata = 0xDEADBEEF.
- Long write 0x11223344 at 0x...01 to an 8-bit port → four cycles at addresses 1, 2, 3, 4 with SIZ 00, 11, 10, 01; D31:24 carries 11, 22, 33, 44 in order.
- Word read at 0x...03 from a 16-bit port → two cycles: the first at addr 3 (lane D23:16 = 0xAB), the second at addr 4 (lane D31:24 = 0xCD); rdata = 0x0000ABCD.
- /BERR during the first cycle of a long write → nAS negates, nBGACK releases, done with err=1, no second cycle.
- No DSACK for TIMEOUT clocks → abort with err=1; the bus is released within 4 clocks after the target's DSACK/BERR are negated.
- nBG held high for 50 clocks, then low while nASI=0 → no nAS until nASI=1. nRST pulsed in WAIT → all outputs return to reset values asynchronously.
